// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with optional hardwired r0, same-cycle write bypass and a
// per-register pending-write scoreboard that gives issue logic a ready flag per read port.
module regfile_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 32,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           RegWr,
  input  logic [ADDR_WIDTH-1:0]          Rw,
  input  logic [DATA_WIDTH-1:0]          busW,
  input  logic                           Iss,
  input  logic [ADDR_WIDTH-1:0]          Rd_iss,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] Rr,
  output logic [NUM_READ*DATA_WIDTH-1:0] busR,
  output logic [NUM_READ-1:0]            Rdy,
  output logic [NUM_REGS-1:0]            Busy
);

  localparam logic [ADDR_WIDTH:0] LP_NUM_REGS = (ADDR_WIDTH+1)'(NUM_REGS);
  // With a hardwired r0 the loops skip register 0 entirely, so it can never be written or marked.
  localparam int LP_FIRST = (ZERO_REG != 0) ? 1 : 0;

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   r_busy;
  logic                  w_wr_valid;
  logic                  w_iss_valid;

  assign w_wr_valid  = RegWr && ({1'b0, Rw} < LP_NUM_REGS)
                       && !((ZERO_REG != 0) && (Rw == '0));
  assign w_iss_valid = Iss && ({1'b0, Rd_iss} < LP_NUM_REGS)
                       && !((ZERO_REG != 0) && (Rd_iss == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      for (int i = LP_FIRST; i < NUM_REGS; i++) begin
        if (w_wr_valid && (Rw == ADDR_WIDTH'(i))) begin
          r_regs[i] <= busW;
        end
        // A new issue to a register outranks the writeback retiring its previous pending write.
        if (w_iss_valid && (Rd_iss == ADDR_WIDTH'(i))) begin
          r_busy[i] <= 1'b1;
        end else if (w_wr_valid && (Rw == ADDR_WIDTH'(i))) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  assign Busy = r_busy;

  always_comb begin
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_rdy;
    w_addr = '0;
    w_data = '0;
    w_rdy  = 1'b1;
    busR   = '0;
    Rdy    = '1;
    for (int p = 0; p < NUM_READ; p++) begin
      w_addr = Rr[p*ADDR_WIDTH +: ADDR_WIDTH];
      w_data = '0;
      w_rdy  = 1'b1;
      for (int i = LP_FIRST; i < NUM_REGS; i++) begin
        if (w_addr == ADDR_WIDTH'(i)) begin
          w_data = r_regs[i];
          w_rdy  = ~r_busy[i];
        end
      end
      // Ready stays on registered state; only the data path sees the in-flight write.
      if ((BYPASS != 0) && w_wr_valid && (w_addr == Rw)) begin
        w_data = busW;
      end
      busR[p*DATA_WIDTH +: DATA_WIDTH] = w_data;
      Rdy[p] = w_rdy;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: a default 32x2 bypassing instance and a 24x3 non-bypassing
// instance share write/issue stimulus and are checked against an array-based reference model.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_wr;
  logic [4:0]  rw;
  logic [31:0] bus_w;
  logic        iss;
  logic [4:0]  rd_iss;
  logic [9:0]  rr1;
  logic [63:0] bus_r1;
  logic [1:0]  rdy1;
  logic [31:0] busy1;
  logic [14:0] rr2;
  logic [95:0] bus_r2;
  logic [2:0]  rdy2;
  logic [23:0] busy2;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  logic [31:0] m1_reg [32];
  logic        m1_busy[32];
  logic [31:0] m2_reg [24];
  logic        m2_busy[24];

  // clock / reset
  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk(clk), .rst(rst), .RegWr(reg_wr), .Rw(rw), .busW(bus_w), .Iss(iss), .Rd_iss(rd_iss),
    .Rr(rr1), .busR(bus_r1), .Rdy(rdy1), .Busy(busy1)
  );

  regfile_scoreboard #(.NUM_REGS(24), .NUM_READ(3), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .RegWr(reg_wr), .Rw(rw), .busW(bus_w), .Iss(iss), .Rd_iss(rd_iss),
    .Rr(rr2), .busR(bus_r2), .Rdy(rdy2), .Busy(busy2)
  );

  // reference model
  function automatic logic [31:0] exp_data(int n, bit bypass, logic [4:0] a);
    if (a == 0 || a >= n) return 32'h0;
    if (bypass && reg_wr && rw == a) return bus_w;
    return (n == 32) ? m1_reg[a] : m2_reg[a];
  endfunction

  function automatic logic exp_rdy(int n, logic [4:0] a);
    if (a == 0 || a >= n) return 1'b1;
    return (n == 32) ? !m1_busy[a] : !m2_busy[a];
  endfunction

  function automatic logic [31:0] exp_busy1();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m1_busy[i];
    return v;
  endfunction

  function automatic logic [23:0] exp_busy2();
    logic [23:0] v;
    for (int i = 0; i < 24; i++) v[i] = m2_busy[i];
    return v;
  endfunction

  task automatic model_update();
    if (rst) begin
      for (int i = 0; i < 32; i++) begin m1_reg[i] = 0; m1_busy[i] = 0; end
      for (int i = 0; i < 24; i++) begin m2_reg[i] = 0; m2_busy[i] = 0; end
    end else begin
      if (reg_wr && rw != 0) begin
        m1_reg[rw] = bus_w; m1_busy[rw] = 0;
        if (rw < 24) begin m2_reg[rw] = bus_w; m2_busy[rw] = 0; end
      end
      if (iss && rd_iss != 0) begin
        m1_busy[rd_iss] = 1;
        if (rd_iss < 24) m2_busy[rd_iss] = 1;
      end
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    rst = 0; reg_wr = 0; iss = 0;
  endtask

  task automatic drive(bit wr, logic [4:0] w_addr, logic [31:0] w_data, bit is, logic [4:0] i_addr);
    reg_wr = wr; rw = w_addr; bus_w = w_data; iss = is; rd_iss = i_addr;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'($urandom_range(0, 1)),
            5'($urandom_range(1, 31)));
      tick();
    end
    rst = 1; reg_wr = 1; iss = 1; rw = 5'd9; rd_iss = 5'd9;
    tick();
    idle();
    #1;
    total++;
    if (busy1 !== 32'h0) begin bad++; $display("FAIL reset_busy1: got %h expected 0", busy1); end
    total++;
    if (busy2 !== 24'h0) begin bad++; $display("FAIL reset_busy2: got %h expected 0", busy2); end
    for (int a = 0; a < 32; a++) begin
      rr1 = {2{5'(a)}}; rr2 = {3{5'(a)}};
      #1;
      total++;
      if (bus_r1 !== 64'h0 || rdy1 !== 2'b11) begin
        bad++; $display("FAIL reset_read1 a=%0d: got %h/%b expected 0/11", a, bus_r1, rdy1);
      end
      total++;
      if (bus_r2 !== 96'h0 || rdy2 !== 3'b111) begin
        bad++; $display("FAIL reset_read2 a=%0d: got %h/%b expected 0/111", a, bus_r2, rdy2);
      end
    end
    // pending write forgotten across reset, later write still lands
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd10);
    tick();
    idle(); rst = 1;
    tick();
    idle();
    total++;
    if (busy1[10] !== 1'b0) begin bad++; $display("FAIL midreset_busy: got %b expected 0", busy1[10]); end
    drive(1'b1, 5'd10, 32'hCAFE0010, 1'b0, 5'd0);
    tick();
    idle(); rr1 = {5'd0, 5'd10};
    #1;
    total++;
    if (bus_r1[31:0] !== 32'hCAFE0010 || rdy1[0] !== 1'b1) begin
      bad++; $display("FAIL midreset_write: got %h/%b expected cafe0010/1", bus_r1[31:0], rdy1[0]);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] old2;
    idle();
    old2 = m2_reg[5];
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
    rr1 = {5'd0, 5'd5}; rr2 = {10'd0, 5'd5};
    #1;
    total++;
    if (bus_r1[31:0] !== 32'hDEADBEEF) begin
      bad++; $display("FAIL bypass_same_cycle: got %h expected deadbeef", bus_r1[31:0]);
    end
    total++;
    if (bus_r2[31:0] !== old2) begin
      bad++; $display("FAIL nobypass_old: got %h expected %h", bus_r2[31:0], old2);
    end
    tick();
    idle();
    #1;
    total++;
    if (bus_r1[31:0] !== 32'hDEADBEEF || bus_r2[31:0] !== 32'hDEADBEEF) begin
      bad++; $display("FAIL bypass_after_edge: got %h/%h expected deadbeef", bus_r1[31:0], bus_r2[31:0]);
    end
  endtask

  task automatic test_zero_reg();
    drive(1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0);
    rr1 = 10'd0;
    #1;
    total++;
    if (bus_r1[31:0] !== 32'h0) begin bad++; $display("FAIL zero_bypass: got %h expected 0", bus_r1[31:0]); end
    tick();
    idle();
    #1;
    total++;
    if (bus_r1[31:0] !== 32'h0 || busy1[0] !== 1'b0 || rdy1[0] !== 1'b1) begin
      bad++; $display("FAIL zero_reg: got %h/%b/%b expected 0/0/1", bus_r1[31:0], busy1[0], rdy1[0]);
    end
  endtask

  task automatic test_scoreboard();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    rr1 = {5'd7, 5'd7};
    #1;
    total++;
    if (rdy1 !== 2'b11) begin bad++; $display("FAIL rdy_no_same_cycle_set: got %b expected 11", rdy1); end
    tick();
    idle();
    #1;
    total++;
    if (busy1[7] !== 1'b1 || rdy1 !== 2'b00) begin
      bad++; $display("FAIL issue_busy: got %b/%b expected 1/00", busy1[7], rdy1);
    end
    drive(1'b1, 5'd7, 32'd9, 1'b0, 5'd0);
    #1;
    total++;
    if (rdy1 !== 2'b00) begin bad++; $display("FAIL rdy_no_same_cycle_clear: got %b expected 00", rdy1); end
    tick();
    idle();
    #1;
    total++;
    if (busy1[7] !== 1'b0 || rdy1[0] !== 1'b1 || bus_r1[31:0] !== 32'd9) begin
      bad++; $display("FAIL writeback_clear: got %b/%b/%h expected 0/1/9", busy1[7], rdy1[0], bus_r1[31:0]);
    end
  endtask

  task automatic test_set_beats_clear();
    drive(1'b1, 5'd3, 32'd4, 1'b1, 5'd3);
    tick();
    idle(); rr1 = {5'd0, 5'd3};
    #1;
    total++;
    if (bus_r1[31:0] !== 32'd4 || busy1[3] !== 1'b1 || rdy1[0] !== 1'b0) begin
      bad++; $display("FAIL set_beats_clear: got %h/%b/%b expected 4/1/0", bus_r1[31:0], busy1[3], rdy1[0]);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] v [3];
    logic [4:0]  a [3];
    a[0] = 5'd1; a[1] = 5'd2; a[2] = 5'd23;
    drive(1'b1, 5'd30, $urandom, 1'b1, 5'd30);
    rr2 = {10'd0, 5'd30};
    #1;
    total++;
    if (bus_r2[31:0] !== 32'h0 || rdy2[0] !== 1'b1) begin
      bad++; $display("FAIL oob_read: got %h/%b expected 0/1", bus_r2[31:0], rdy2[0]);
    end
    tick();
    idle();
    #1;
    total++;
    if (busy2 !== exp_busy2() || bus_r2[31:0] !== 32'h0) begin
      bad++; $display("FAIL oob_write: got %h/%h expected %h/0", busy2, bus_r2[31:0], exp_busy2());
    end
    v[0] = $urandom; v[1] = v[0] ^ 32'h1; v[2] = v[0] ^ 32'h80000002;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, a[k], v[k], 1'b0, 5'd0);
      tick();
    end
    idle(); rr2 = {5'd23, 5'd2, 5'd1};
    #1;
    for (int p = 0; p < 3; p++) begin
      total++;
      if (bus_r2[p*32 +: 32] !== v[p]) begin
        bad++; $display("FAIL three_port p=%0d: got %h expected %h", p, bus_r2[p*32 +: 32], v[p]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] e;
    logic [31:0] got;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 39) == 0);
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      for (int p = 0; p < 2; p++)
        rr1[p*5 +: 5] = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom_range(0, 31));
      for (int p = 0; p < 3; p++)
        rr2[p*5 +: 5] = ($urandom_range(0, 3) == 0) ? rw : 5'($urandom_range(0, 31));
      #1;
      for (int p = 0; p < 2; p++) exp_q.push_back(exp_data(32, 1'b1, rr1[p*5 +: 5]));
      for (int p = 0; p < 3; p++) exp_q.push_back(exp_data(24, 1'b0, rr2[p*5 +: 5]));
      for (int p = 0; p < 2; p++) begin
        got = bus_r1[p*32 +: 32]; e = exp_q.pop_front();
        total++;
        if (got !== e) begin bad++; $display("FAIL rand_read1 c=%0d p=%0d: got %h expected %h", c, p, got, e); end
        total++;
        if (rdy1[p] !== exp_rdy(32, rr1[p*5 +: 5])) begin
          bad++; $display("FAIL rand_rdy1 c=%0d p=%0d: got %b expected %b", c, p, rdy1[p], exp_rdy(32, rr1[p*5 +: 5]));
        end
      end
      for (int p = 0; p < 3; p++) begin
        got = bus_r2[p*32 +: 32]; e = exp_q.pop_front();
        total++;
        if (got !== e) begin bad++; $display("FAIL rand_read2 c=%0d p=%0d: got %h expected %h", c, p, got, e); end
        total++;
        if (rdy2[p] !== exp_rdy(24, rr2[p*5 +: 5])) begin
          bad++; $display("FAIL rand_rdy2 c=%0d p=%0d: got %b expected %b", c, p, rdy2[p], exp_rdy(24, rr2[p*5 +: 5]));
        end
      end
      total++;
      if (busy1 !== exp_busy1() || busy2 !== exp_busy2()) begin
        bad++; $display("FAIL rand_busy c=%0d: got %h/%h expected %h/%h", c, busy1, busy2, exp_busy1(), exp_busy2());
      end
      tick();
    end
    idle();
  endtask

  initial begin
    rst = 1; reg_wr = 0; iss = 0; rw = 0; rd_iss = 0; bus_w = 0; rr1 = 0; rr2 = 0;
    tick();
    tick();
    idle();
    test_reset();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_set_beats_clear();
    test_out_of_range();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
